// File: rtl/chirp_pkg.sv
`default_nettype none
// ============================================================================
// chirp_pkg : shared widths and state encoding for the chirp sweep generator
// Revision  : 1.0
// ============================================================================
package chirp_pkg;

    localparam int CHIRP_W  = 16;
    localparam int CHIRP_DW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : chirp_pkg
`default_nettype wire

// File: rtl/chirp_sat_step.sv
`default_nettype none
// ============================================================================
// chirp_sat_step : one saturating frequency step, up (clamp to limit from
//                  above) or down (clamp to limit from below), never wrapping
// Revision       : 1.0
// ============================================================================
module chirp_sat_step
    import chirp_pkg::*;
#(
    parameter int W = CHIRP_W
) (
    input  logic [W-1:0] value,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    input  logic         dir,
    output logic [W-1:0] result
);

    logic [W:0] sum;
    logic [W:0] diff;

    // One extra bit catches both carry-out and borrow
    assign sum  = {1'b0, value} + {1'b0, step};
    assign diff = {1'b0, value} - {1'b0, step};

    always_comb begin
        if (dir) begin
            result = (sum > {1'b0, limit}) ? limit : sum[W-1:0];
        end else begin
            result = (diff[W] || (diff[W-1:0] < limit)) ? limit : diff[W-1:0];
        end
    end

endmodule : chirp_sat_step
`default_nettype wire

// File: rtl/chirp_sweep_gen.sv
`default_nettype none
// ============================================================================
// chirp_sweep_gen : stepped frequency sweep feeding a phase accumulator.
//                   CHIRP_TRIANGLE_EN adds tri_mode and the DOWN leg.
//                   The repeat control is port repeat_i (repeat is a keyword).
// Revision        : 1.0
// ============================================================================
module chirp_sweep_gen
    import chirp_pkg::*;
#(
    parameter int W  = CHIRP_W,
    parameter int DW = CHIRP_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  f_start,
    input  logic [W-1:0]  f_stop,
    input  logic [W-1:0]  f_step,
    input  logic [DW-1:0] dwell,
    input  logic          repeat_i,
`ifdef CHIRP_TRIANGLE_EN
    input  logic          tri_mode,
`endif
    input  logic          inc_ready,
    output logic [W-1:0]  phase_inc,
    output logic          inc_valid,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [W-1:0]  phase_q, phase_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  f_start_q, f_stop_q, f_step_q;
    logic [DW-1:0] dwell_q;
    logic          repeat_q;

    logic          load, accept, step_now, at_top, at_bot, at_end, to_down, dir_up;
    logic [W-1:0]  step_next;

    assign load     = (state_q == ST_IDLE) && start && !abort;
    assign accept   = busy && inc_ready;
    assign step_now = accept && (cnt_q == dwell_q);
    assign at_top   = (phase_q >= f_stop_q);
    assign at_bot   = (phase_q <= f_start_q);
    assign at_end   = ((state_q == ST_UP) && at_top) || ((state_q == ST_DOWN) && at_bot);
    assign dir_up   = (state_q == ST_UP) && !at_top;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            repeat_q  <= 1'b0;
        end else if (load) begin
            f_start_q <= f_start;
            f_stop_q  <= f_stop;
            f_step_q  <= (f_step == '0) ? W'(1) : f_step;
            dwell_q   <= dwell;
            repeat_q  <= repeat_i;
        end
    end

`ifdef CHIRP_TRIANGLE_EN
    logic tri_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q <= 1'b0;
        end else if (load) begin
            tri_q <= tri_mode;
        end
    end

    // A one-frequency sweep (start >= stop) never turns around
    assign to_down = (state_q == ST_UP) && at_top && tri_q && (f_start_q < f_stop_q);
`else
    assign to_down = 1'b0;
`endif

    chirp_sat_step #(.W(W)) u_sat_step (
        .value  (phase_q),
        .step   (f_step_q),
        .limit  (dir_up ? f_stop_q : f_start_q),
        .dir    (dir_up),
        .result (step_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_UP;
`ifdef CHIRP_TRIANGLE_EN
            ST_UP, ST_DOWN: begin
`else
            ST_UP: begin
`endif
                if (step_now && at_end) begin
                    state_d = to_down ? ST_DOWN : (repeat_q ? ST_UP : ST_DONE);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) state_d = ST_IDLE;
    end

    always_comb begin
        busy      = (state_q == ST_UP) || (state_q == ST_DOWN);
        inc_valid = busy;
        done      = (state_q == ST_DONE);
    end

    // Abort freezes phase_inc and drops any step pending this cycle
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (load) begin
            phase_d = f_start;
            cnt_d   = '0;
        end else if (accept) begin
            if (step_now) begin
                cnt_d = '0;
                if (to_down || !at_end) begin
                    phase_d = step_next;
                end else if (repeat_q) begin
                    phase_d = f_start_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    assign phase_inc = phase_q;

endmodule : chirp_sweep_gen
`default_nettype wire

// File: tb/tb_chirp_sweep_gen.sv
`default_nettype none
// ============================================================================
// tb_chirp_sweep_gen : scoreboard bench for chirp_sweep_gen; triangle cases
//                      are included when CHIRP_TRIANGLE_EN is defined.
// Revision           : 1.0
// ============================================================================
module tb_chirp_sweep_gen;

    localparam int W  = 16;
    localparam int DW = 8;
`ifdef CHIRP_TRIANGLE_EN
    localparam bit TRI_EN = 1'b1;
`else
    localparam bit TRI_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort, repeat_i, inc_ready;
    logic [W-1:0]  f_start, f_stop, f_step;
    logic [DW-1:0] dwell;
`ifdef CHIRP_TRIANGLE_EN
    logic          tri_mode;
`endif
    logic [W-1:0]  phase_inc;
    logic          inc_valid, busy, done;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int done_cnt = 0;
    int busy_cycles = 0;

    chirp_sweep_gen #(.W(W), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .repeat_i  (repeat_i),
`ifdef CHIRP_TRIANGLE_EN
        .tri_mode  (tri_mode),
`endif
        .inc_ready (inc_ready),
        .phase_inc (phase_inc),
        .inc_valid (inc_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every valid cycle must show the scoreboard head; pop on accept
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("valid_eq_busy", {31'd0, inc_valid}, {31'd0, busy});
            if (inc_valid === 1'b1) begin
                busy_cycles++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    check("phase_inc", {16'd0, phase_inc}, sb[0]);
                    if (inc_ready === 1'b1) void'(sb.pop_front());
                end
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_model(input int fs, input int fe, input int st, input int dw,
                              input bit tm, output int last, output int nvals);
        int s;
        int v;
        s = (st == 0) ? 1 : st;
        v = fs;
        nvals = 0;
        for (int k = 0; k <= dw; k++) sb.push_back(v);
        nvals++;
        if (fs < fe) begin
            while (v != fe) begin
                v = (v + s > fe) ? fe : v + s;
                for (int k = 0; k <= dw; k++) sb.push_back(v);
                nvals++;
            end
            if (tm && TRI_EN) begin
                while (v != fs) begin
                    v = (v - s < fs) ? fs : v - s;
                    for (int k = 0; k <= dw; k++) sb.push_back(v);
                    nvals++;
                end
            end
        end
        last = v;
    endtask

    task automatic launch(input int fs, input int fe, input int st, input int dw,
                          input bit rp, input bit tm);
        f_start  = W'(fs);
        f_stop   = W'(fe);
        f_step   = W'(st);
        dwell    = DW'(dw);
        repeat_i = rp;
`ifdef CHIRP_TRIANGLE_EN
        tri_mode = tm;
`else
        if (tm) begin end
`endif
        done_cnt    = 0;
        busy_cycles = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic full_sweep(input int fs, input int fe, input int st, input int dw,
                              input bit tm, input int stall_at, input int stall_len);
        int last;
        int nvals;
        int n;
        push_model(fs, fe, st, dw, tm, last, nvals);
        launch(fs, fe, st, dw, 1'b0, tm);
        if (stall_len > 0) begin
            tick(stall_at);
            inc_ready = 1'b0;
            tick(stall_len);
            inc_ready = 1'b1;
        end
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        check("done_phase", {16'd0, phase_inc}, last);
        check("done_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);
        check("done_pulses", done_cnt, 32'd1);
        check("sweep_len", busy_cycles, nvals * (dw + 1) + stall_len);
        tick(1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; repeat_i = 1'b0; inc_ready = 1'b1;
        f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
`ifdef CHIRP_TRIANGLE_EN
        tri_mode = 1'b0;
`endif
        tick(3);
        @(negedge clk);
        check("rst_phase", {16'd0, phase_inc}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, inc_valid}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(2);

        full_sweep(100, 130, 10, 2, 1'b0, 0, 0);
        full_sweep(100, 125, 10, 2, 1'b0, 0, 0);
        full_sweep(16'hFFF0, 16'hFFFF, 16'h20, 0, 1'b0, 0, 0);
        full_sweep(100, 130, 10, 2, 1'b0, 4, 5);
        full_sweep(10, 13, 0, 0, 1'b0, 0, 0);
        full_sweep(200, 150, 5, 1, 1'b1, 0, 0);
        full_sweep(100, 120, 10, 0, 1'b1, 0, 0);

        // Start while busy is ignored; abort lands on a step cycle
        sb.push_back(100); sb.push_back(100); sb.push_back(110); sb.push_back(110);
        launch(100, 200, 10, 1, 1'b0, 1'b0);
        tick(1);
        start = 1'b1; f_start = 16'd500;
        tick(1);
        start = 1'b0; f_start = 16'd100;
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_phase", {16'd0, phase_inc}, 32'd110);
        tick(3);
        check("abort_no_done", done_cnt, 32'd0);
        check("abort_sb_empty", sb.size(), 32'd0);

        // Repeat wraps to f_start after the top, then abort
        sb.push_back(100); sb.push_back(110); sb.push_back(120);
        sb.push_back(100); sb.push_back(110);
        launch(100, 120, 10, 0, 1'b1, 1'b0);
        tick(4);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        @(negedge clk);
        check("rpt_busy", {31'd0, busy}, 32'd0);
        check("rpt_phase", {16'd0, phase_inc}, 32'd110);
        tick(3);
        check("rpt_no_done", done_cnt, 32'd0);
        check("rpt_sb_empty", sb.size(), 32'd0);

        // Reset mid-sweep discards the sweep silently
        sb.push_back(100); sb.push_back(110);
        launch(100, 130, 10, 0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        check("mrst_phase", {16'd0, phase_inc}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        tick(3);
        check("mrst_no_done", done_cnt, 32'd0);
        check("mrst_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_chirp_sweep_gen
`default_nettype wire
